mux_scan_sampler: RTL and testbench
===================================

# mux_scan_sampler

Sequencer that sits directly upstream of the 4:1 structural multiplexer: it drives the mux address and enable lines, scanning channels 0 to 3 in order. After each address change it waits a programmable settle time, then samples the mux output. The four samples are packed into a 4-bit frame and presented downstream on a valid/ready handshake with a one-entry output register.

## Interface
- `SETTLE_CYCLES`, default 2: cycles the address is held before sampling; legal range 1 to 15.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to begin a scan; honoured only in IDLE.
- `continuous`  in  1  when 1, a new scan starts automatically after each frame handoff.
- `mux_out`  in  1  output of the downstream 4:1 mux.
- `address0`  out  1  mux select LSB, registered.
- `address1`  out  1  mux select MSB, registered.
- `mux_enable`  out  1  mux enable, registered.
- `frame_data`  out  4  bit k holds the channel-k sample.
- `frame_valid`  out  1  `frame_data` holds an unconsumed frame.
- `frame_ready`  in  1  consumer accepts the frame when it is high together with `frame_valid`.
- `busy`  out  1  high in every state except IDLE.

## Operation
- States:
  - IDLE
  - SETTLE: settle counter running.
  - SAMPLE: one cycle; `mux_out` captured into work bit ch.
  - HOLD: complete frame waiting for the output slot.
- Transitions:
  - IDLE→SETTLE on `start`, or on `continuous`=1 directly after a handoff. ch=0, counter=0.
  - SETTLE→SAMPLE when counter reaches SETTLE_CYCLES−1.
  - SAMPLE with ch<3 → SETTLE, with ch+1 and counter cleared.
  - SAMPLE with ch=3 → handoff if the slot is free (`!frame_valid || frame_ready`), else → HOLD.
  - HOLD → handoff once the slot is free.
  - Handoff: load `frame_data`, set `frame_valid`, then go to SETTLE(ch=0) if `continuous`, else IDLE.
- `{address1,address0}` = ch and `mux_enable`=1 in SETTLE and SAMPLE.
- `{address1,address0}` = 0 and `mux_enable`=0 in IDLE and HOLD.
- `frame_valid` clears on `frame_valid && frame_ready`, unless a handoff in the same cycle reloads it; in that case it stays 1 and the new data wins.
- `start` while busy is ignored, not queued.
- The counter is 4 bits wide; ch is 2 bits and never wraps past 3 within a frame.

## Timing
- Reset values: `address0`=0, `address1`=0, `mux_enable`=0, `frame_data`=0, `frame_valid`=0, `busy`=0, state=IDLE.
- Reset asserted mid-scan discards the work frame and any held frame immediately; no partial frame is ever presented.
- With `start` high in cycle 0:
  - Address k is driven from cycle k·(S+1)+1, where S = SETTLE_CYCLES.
  - Channel k is sampled at the end of cycle (k+1)·(S+1).
  - `frame_valid` rises in cycle 4·(S+1)+1, i.e. cycle 13 for S=2.
- In continuous mode with `frame_ready` held at 1, frames are spaced exactly 4·(S+1) cycles apart: the handoff cycle and the first SETTLE cycle coincide.
- A sample edge in the same cycle as `frame_ready` frees the slot still hands off with no bubble.
- Backpressure: the scan stalls in HOLD; `mux_enable`=0 while stalled; no frame is dropped.

## Configuration
- Macro `MUX_SCAN_MASK_EN`.
- Defined:
  - Adds input `chan_mask` (4 bits); bit k=1 skips channel k.
  - A skipped channel is never addressed, takes no cycles, and its frame bit is 0.
  - `chan_mask` is sampled at scan start and frozen for that scan.
  - Mask 4'b1111: start goes straight to the handoff check, and an all-zero frame appears on the next cycle.
- Undefined: no `chan_mask` port; all four channels are always scanned.

## Structure
- Package `mux_scan_pkg` holds:
  - state enum (IDLE, SETTLE, SAMPLE, HOLD)
  - `NUM_CH`=4, `CH_W`=2, `CNT_W`=4
- One sub-module, `mux_scan_settle_timer`: loadable down-counter with `clear`, `run` and `done` signals, parameterised by SETTLE_CYCLES.

## Test plan
- Model mux inputs 1,0,1,1 (ch0..ch3). Pulse `start`, S=2, `frame_ready`=1. Expect `frame_valid` in cycle 13 with `frame_data`=4'b1101, address sequence 0,1,2,3 each held 3 cycles, then IDLE.
- `frame_ready`=0 with `continuous`=1. Expect the first frame held, the second scan stalled in HOLD with `mux_enable`=0. Raise ready: the first frame is consumed and the second is presented next cycle, with no loss and no duplicate.
- Assert `rst_n` low during channel 2 settle. Expect all outputs at reset values at once; after release and a new `start`, a correct full frame.
- `start` pulsed again during a scan. Expect no effect on timing or data.
- With `MUX_SCAN_MASK_EN` defined:
  - `chan_mask`=4'b0101: expect only addresses 1 and 3, frame bits 0 and 2 forced to 0, and valid at cycle 2·(S+1)+1.
  - `chan_mask`=4'b1111: expect an all-zero frame one cycle after `start`.

Source files
------------

// File: rtl/mux_scan_sampler_pkg.sv
// Shared types, widths and channel-pick helper for the mux scan sampler.
package mux_scan_pkg;

    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        HOLD   = 2'd3
    } scan_state_e;

    // Plain-vector state encodings used by the FSM register
    localparam logic [1:0] ST_IDLE   = IDLE;
    localparam logic [1:0] ST_SETTLE = SETTLE;
    localparam logic [1:0] ST_SAMPLE = SAMPLE;
    localparam logic [1:0] ST_HOLD   = HOLD;

    typedef struct packed {
        logic            found;
        logic [CH_W-1:0] ch;
    } chan_pick_t;

    // Lowest unmasked channel at or above 'from'; found=0 when none remain.
    function automatic chan_pick_t find_chan(input logic [NUM_CH-1:0] mask,
                                             input logic [CH_W:0]     from);
        chan_pick_t pick;
        pick = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (k >= int'(from) && !mask[k]) begin
                pick.found = 1'b1;
                pick.ch    = CH_W'(k);
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/mux_scan_sampler_if.sv
// Mux select/sample bus plus the downstream frame valid/ready stream.
interface mux_scan_sampler_if
    import mux_scan_pkg::*;
();
    logic              address0;
    logic              address1;
    logic              mux_enable;
    logic              mux_out;
    logic [NUM_CH-1:0] frame_data;
    logic              frame_valid;
    logic              frame_ready;

    modport master (
        output address0, address1, mux_enable, frame_data, frame_valid,
        input  mux_out, frame_ready
    );

    modport slave (
        input  address0, address1, mux_enable, frame_data, frame_valid,
        output mux_out, frame_ready
    );
endinterface

// File: rtl/mux_scan_sampler_settle_timer.sv
// Settle timer: loads SETTLE_CYCLES-1 on clear, counts down while run,
// done when the count is zero (legal SETTLE_CYCLES range 1..15).
module mux_scan_settle_timer
    import mux_scan_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    output logic done
);
    localparam logic [CNT_W-1:0] LOAD = CNT_W'(SETTLE_CYCLES - 1);

    logic [CNT_W-1:0] count;

    // Down-counter: reload on clear, decrement toward zero while running
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= LOAD;
        end else if (run && count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

    assign done = (count == '0);
endmodule

// File: rtl/mux_scan_sampler.sv
// Scans a 4:1 mux channel by channel, waits SETTLE_CYCLES after each
// address change, samples, and hands the packed 4-bit frame downstream
// through a one-entry valid/ready output register.
// Optional build macro MUX_SCAN_MASK_EN adds a per-channel skip mask.
module mux_scan_sampler
    import mux_scan_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              continuous,
    output logic              busy,
`ifdef MUX_SCAN_MASK_EN
    input  logic [NUM_CH-1:0] chan_mask,
`endif
    mux_scan_sampler_if.master bus
);
    logic [1:0]        state_q, state_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [NUM_CH-1:0] work_q, work_d;
    logic [NUM_CH-1:0] mask_q, mask_d;
    logic [NUM_CH-1:0] launch_mask;
    logic [NUM_CH-1:0] frame_data_q;
    logic [NUM_CH-1:0] handoff_data;
    logic              frame_valid_q;
    logic [CH_W-1:0]   addr_q;
    logic              enable_q;
    logic              slot_free;
    logic              handoff;
    logic              launch;
    logic              scanning_d;
    logic              timer_clear;
    logic              timer_run;
    logic              timer_done;
    chan_pick_t        first_pick;
    chan_pick_t        next_pick;

`ifdef MUX_SCAN_MASK_EN
    assign launch_mask = chan_mask;
`else
    assign launch_mask = '0;
`endif

    assign slot_free = !frame_valid_q || bus.frame_ready;

    mux_scan_settle_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_timer (
        .clk  (clk),
        .rst_n(rst_n),
        .clear(timer_clear),
        .run  (timer_run),
        .done (timer_done)
    );

    // Next-state, channel stepping, frame assembly and handoff decision
    always_comb begin
        state_d      = state_q;
        ch_d         = ch_q;
        work_d       = work_q;
        mask_d       = mask_q;
        timer_clear  = 1'b0;
        timer_run    = 1'b0;
        handoff      = 1'b0;
        handoff_data = work_q;
        launch       = 1'b0;
        first_pick   = find_chan(launch_mask, '0);
        next_pick    = find_chan(mask_q, (CH_W + 1)'(ch_q) + (CH_W + 1)'(1));

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    launch = 1'b1;
                end
            end
            ST_SETTLE: begin
                timer_run = 1'b1;
                if (timer_done) begin
                    state_d = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                work_d[ch_q] = bus.mux_out;
                if (next_pick.found) begin
                    state_d     = ST_SETTLE;
                    ch_d        = next_pick.ch;
                    timer_clear = 1'b1;
                end else if (slot_free) begin
                    handoff      = 1'b1;
                    handoff_data = work_d;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (slot_free) begin
                    handoff = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A handoff either restarts the scan in the same cycle or parks in IDLE
        if (handoff) begin
            if (continuous) begin
                launch = 1'b1;
            end else begin
                state_d = ST_IDLE;
            end
        end

        // Scan launch: freeze the mask, clear the work frame, pick channel 0..3
        if (launch) begin
            mask_d = launch_mask;
            work_d = '0;
            ch_d   = first_pick.ch;
            if (first_pick.found) begin
                state_d     = ST_SETTLE;
                timer_clear = 1'b1;
            end else if (!handoff && slot_free) begin
                // Fully masked scan from IDLE: empty frame goes out immediately
                handoff      = 1'b1;
                handoff_data = '0;
                state_d      = continuous ? ST_HOLD : ST_IDLE;
            end else begin
                state_d = ST_HOLD;
            end
        end
    end

    assign scanning_d = (state_d == ST_SETTLE) || (state_d == ST_SAMPLE);

    // FSM state, current channel, frozen mask and work frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ch_q    <= '0;
            work_q  <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            work_q  <= work_d;
            mask_q  <= mask_d;
        end
    end

    // One-entry output slot; a same-cycle reload keeps valid high with new data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_data_q  <= '0;
            frame_valid_q <= 1'b0;
        end else if (handoff) begin
            frame_data_q  <= handoff_data;
            frame_valid_q <= 1'b1;
        end else if (frame_valid_q && bus.frame_ready) begin
            frame_valid_q <= 1'b0;
        end
    end

    // Registered mux select/enable, aligned with the state being entered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q   <= '0;
            enable_q <= 1'b0;
        end else begin
            addr_q   <= scanning_d ? ch_d : '0;
            enable_q <= scanning_d;
        end
    end

    assign bus.address0    = addr_q[0];
    assign bus.address1    = addr_q[1];
    assign bus.mux_enable  = enable_q;
    assign bus.frame_data  = frame_data_q;
    assign bus.frame_valid = frame_valid_q;
    assign busy            = (state_q != ST_IDLE);
endmodule

// File: tb/tb_mux_scan_sampler.sv
// Bench for mux_scan_sampler: table of scan vectors plus hand-written
// backpressure, continuous, reset and restart sequences; frames are also
// tracked by a scoreboard queue popped on each valid/ready handshake.
module tb_mux_scan_sampler;
    localparam int S = 2;

    typedef struct {
        logic [3:0] pattern;
        logic [3:0] mask;
        logic [3:0] exp_frame;
        int         exp_lat;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       continuous;
    logic       busy;
    logic [3:0] chan_mask;
    logic [3:0] pattern;

    int total = 0;
    int bad   = 0;
    logic [3:0] sb_q[$];
    vec_t vecs[$];

    mux_scan_sampler_if bus_if ();

    mux_scan_sampler #(
        .SETTLE_CYCLES(S)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .continuous(continuous),
        .busy      (busy),
`ifdef MUX_SCAN_MASK_EN
        .chan_mask (chan_mask),
`endif
        .bus       (bus_if)
    );

    // Behavioural 4:1 mux: input k holds pattern[k]
    assign bus_if.mux_out = bus_if.mux_enable ?
                            pattern[{bus_if.address1, bus_if.address0}] : 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: each handshake must deliver the oldest expected frame
    always @(negedge clk) begin
        if (rst_n && bus_if.frame_valid && bus_if.frame_ready) begin
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected: got frame %b expected none", bus_if.frame_data);
            end else begin
                logic [3:0] exp_f;
                exp_f = sb_q.pop_front();
                if (bus_if.frame_data !== exp_f) begin
                    bad++;
                    $display("FAIL sb_frame: got %b expected %b", bus_if.frame_data, exp_f);
                end
            end
        end
    end

    task automatic run_vec(input vec_t v, input string tag);
        int lat;
        int addr_bad;
        int chans[$];
        pattern   = v.pattern;
        chan_mask = v.mask;
        for (int k = 0; k < 4; k++) if (!chan_mask[k]) chans.push_back(k);
        sb_q.push_back(v.exp_frame);
        lat      = 0;
        addr_bad = 0;
        start    = 1'b1;
        for (int n = 1; n <= 60 && lat == 0; n++) begin
            step();
            start = 1'b0;
            if (bus_if.frame_valid) begin
                lat = n;
            end else begin
                int k;
                k = (n - 1) / (S + 1);
                if (k >= chans.size()) addr_bad++;
                else if (bus_if.mux_enable !== 1'b1 ||
                         {bus_if.address1, bus_if.address0} !== 2'(chans[k])) addr_bad++;
            end
        end
        check({tag, "_latency"}, lat, v.exp_lat);
        check({tag, "_frame"}, bus_if.frame_data, v.exp_frame);
        check({tag, "_addr_seq_errs"}, addr_bad, 0);
        step();
        step();
        check({tag, "_idle_busy"}, busy, 0);
        check({tag, "_idle_valid"}, bus_if.frame_valid, 0);
    endtask

    initial begin
        int r1;
        int r2;
        int lat;
        int extra;
        logic prev;

        vecs.push_back('{4'b1101, 4'b0000, 4'b1101, 13});
        vecs.push_back('{4'b0000, 4'b0000, 4'b0000, 13});
        vecs.push_back('{4'b1111, 4'b0000, 4'b1111, 13});
        vecs.push_back('{4'b0110, 4'b0000, 4'b0110, 13});
        vecs.push_back('{4'b1001, 4'b0000, 4'b1001, 13});
`ifdef MUX_SCAN_MASK_EN
        vecs.push_back('{4'b1111, 4'b0101, 4'b1010, 7});
        vecs.push_back('{4'b1111, 4'b1111, 4'b0000, 1});
        vecs.push_back('{4'b1011, 4'b1000, 4'b0011, 10});
        vecs.push_back('{4'b0111, 4'b1110, 4'b0001, 4});
`endif

        rst_n      = 1'b0;
        start      = 1'b0;
        continuous = 1'b0;
        chan_mask  = 4'b0000;
        pattern    = 4'b0000;
        bus_if.frame_ready = 1'b1;
        repeat (3) step();
        check("rst_addr", {bus_if.address1, bus_if.address0}, 0);
        check("rst_enable", bus_if.mux_enable, 0);
        check("rst_valid", bus_if.frame_valid, 0);
        check("rst_data", bus_if.frame_data, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        step();

        // Table of single scans
        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end
        chan_mask = 4'b0000;

        // Backpressure: first frame held, second scan stalls in HOLD
        pattern = 4'b1101;
        continuous = 1'b1;
        bus_if.frame_ready = 1'b0;
        sb_q.push_back(4'b1101);
        sb_q.push_back(4'b0110);
        start = 1'b1;
        repeat (13) begin step(); start = 1'b0; end
        check("bp_first_valid", bus_if.frame_valid, 1);
        check("bp_first_data", bus_if.frame_data, 4'b1101);
        pattern = 4'b0110;
        repeat (17) step();
        check("bp_hold_enable", bus_if.mux_enable, 0);
        check("bp_hold_busy", busy, 1);
        check("bp_hold_data", bus_if.frame_data, 4'b1101);
        check("bp_hold_valid", bus_if.frame_valid, 1);
        continuous = 1'b0;
        bus_if.frame_ready = 1'b1;
        step();
        check("bp_second_valid", bus_if.frame_valid, 1);
        check("bp_second_data", bus_if.frame_data, 4'b0110);
        step();
        step();
        check("bp_done_valid", bus_if.frame_valid, 0);
        check("bp_done_busy", busy, 0);

        // Slot freed on the same edge as the last sample: no bubble
        pattern = 4'b1011;
        continuous = 1'b1;
        bus_if.frame_ready = 1'b0;
        sb_q.push_back(4'b1011);
        sb_q.push_back(4'b0100);
        start = 1'b1;
        repeat (13) begin step(); start = 1'b0; end
        check("nb_first_data", bus_if.frame_data, 4'b1011);
        pattern = 4'b0100;
        continuous = 1'b0;
        repeat (11) step();
        check("nb_sample_enable", bus_if.mux_enable, 1);
        check("nb_sample_addr", {bus_if.address1, bus_if.address0}, 3);
        bus_if.frame_ready = 1'b1;
        step();
        check("nb_second_valid", bus_if.frame_valid, 1);
        check("nb_second_data", bus_if.frame_data, 4'b0100);
        check("nb_idle_busy", busy, 0);
        step();
        check("nb_consumed", bus_if.frame_valid, 0);

        // Continuous spacing with ready held high
        pattern = 4'b1101;
        continuous = 1'b1;
        sb_q.push_back(4'b1101);
        sb_q.push_back(4'b1101);
        r1 = 0;
        r2 = 0;
        prev = 1'b0;
        start = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            step();
            start = 1'b0;
            if (bus_if.frame_valid && !prev) begin
                if (r1 == 0) begin
                    r1 = n;
                    continuous = 1'b0;
                end else if (r2 == 0) begin
                    r2 = n;
                end
            end
            prev = bus_if.frame_valid;
        end
        check("cont_first_rise", r1, 13);
        check("cont_second_rise", r2, 25);
        check("cont_idle_busy", busy, 0);

        // Reset during channel-2 settle, then a clean scan
        pattern = 4'b1111;
        sb_q.push_back(4'b1111);
        start = 1'b1;
        repeat (7) begin step(); start = 1'b0; end
        check("rst_mid_addr_before", {bus_if.address1, bus_if.address0}, 2);
        rst_n = 1'b0;
        sb_q.delete();
        #1;
        check("rst_mid_addr", {bus_if.address1, bus_if.address0}, 0);
        check("rst_mid_enable", bus_if.mux_enable, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_valid", bus_if.frame_valid, 0);
        check("rst_mid_data", bus_if.frame_data, 0);
        step();
        rst_n = 1'b1;
        step();
        run_vec(vecs[0], "post_rst");

        // Start pulses during a scan are ignored
        pattern = 4'b1101;
        sb_q.push_back(4'b1101);
        lat = 0;
        start = 1'b1;
        for (int n = 1; n <= 40 && lat == 0; n++) begin
            step();
            start = (n == 5 || n == 9) ? 1'b1 : 1'b0;
            if (bus_if.frame_valid) lat = n;
        end
        start = 1'b0;
        check("restart_latency", lat, 13);
        check("restart_data", bus_if.frame_data, 4'b1101);
        step();
        extra = 0;
        for (int n = 0; n < 20; n++) begin
            if (bus_if.frame_valid || busy) extra++;
            step();
        end
        check("restart_no_extra", extra, 0);

        check("sb_drained", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
